// File: rtl/adapter_sched_pkg.sv
// Shared types and helpers for the adapter backprop scheduler: state encoding,
// task numbering and the "next enabled task" search.
package adapter_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

    localparam int TASK_BIAS = 0;
    localparam int TASK_W0   = 1;
    localparam int MAX_TASKS = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } task_sel_t;

    // Lowest set bit strictly above cur, or the lowest set bit overall when from_start.
    function automatic task_sel_t next_task(input logic [MAX_TASKS-1:0] mask,
                                            input logic [4:0]           cur,
                                            input logic                 from_start);
        task_sel_t sel;
        sel.found = 1'b0;
        sel.idx   = 5'd0;
        for (int i = MAX_TASKS - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                sel.found = 1'b1;
                sel.idx   = 5'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/adapter_task_pick.sv
// Combinational priority pick of the next enabled gradient task; serves both the
// first selection after start and the advance after each result write.
module adapter_task_pick
    import adapter_sched_pkg::*;
#(
    parameter int N_TASKS = 7,
    parameter int TASK_W  = 3
) (
    input  logic [N_TASKS-1:0] mask,
    input  logic [TASK_W-1:0]  cur,
    input  logic               from_start,
    output logic               found,
    output logic [TASK_W-1:0]  pick
);

    logic [MAX_TASKS-1:0] mask_ext_s;
    task_sel_t            sel_s;

    // Widen the mask to the helper's fixed width and run the search.
    always_comb begin
        mask_ext_s              = '0;
        mask_ext_s[N_TASKS-1:0] = mask;
        sel_s                   = next_task(mask_ext_s, 5'(cur), from_start);
        found                   = sel_s.found;
        pick                    = TASK_W'(sel_s.idx);
    end

endmodule

// File: rtl/adapter_bp_scheduler.sv
// Sequencer for the serial-adapter backprop reductions (bias, then one weight gradient
// per FMAP channel). Optional perf counters are enabled with ADAPT_SCHED_PERF_EN.
module adapter_bp_scheduler
    import adapter_sched_pkg::*;
#(
    parameter int SA_SIZE       = 576,
    parameter int FMAP_CHANNELS = 6,
    parameter int N_TASKS       = FMAP_CHANNELS + 1,
    parameter int ADD_LAT       = 1,
    parameter int IDX_W         = $clog2(SA_SIZE),
    parameter int TASK_W        = (N_TASKS > 1) ? $clog2(N_TASKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_TASKS-1:0] task_mask,
    input  logic               hold,
    output logic               busy,
    output logic [IDX_W-1:0]   idx,
    output logic [TASK_W-1:0]  task_id,
    output logic [N_TASKS-1:0] acc_clear,
    output logic [N_TASKS-1:0] acc_en,
    output logic               res_valid,
    output logic [TASK_W-1:0]  res_task,
    output logic               done,
    output logic               aborted
`ifdef ADAPT_SCHED_PERF_EN
    ,
    output logic [31:0]        run_cycles,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int             DRAIN_W  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SA_SIZE - 1);

    sched_state_t        state_q, state_d;
    logic [N_TASKS-1:0]  mask_q, mask_d;
    logic [TASK_W-1:0]   task_id_q, task_id_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                busy_q, busy_d;
    logic [N_TASKS-1:0]  acc_clear_q, acc_clear_d;
    logic                res_valid_q, res_valid_d;
    logic [TASK_W-1:0]   res_task_q, res_task_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic                in_idle_s;
    logic                start_acc_s;
    logic [N_TASKS-1:0]  pick_mask_s;
    logic                pick_found_s;
    logic [TASK_W-1:0]   pick_s;

    assign in_idle_s   = (state_q == ST_IDLE);
    assign start_acc_s = in_idle_s && start && !abort;
    assign pick_mask_s = in_idle_s ? task_mask : mask_q;

    adapter_task_pick #(
        .N_TASKS (N_TASKS),
        .TASK_W  (TASK_W)
    ) u_pick (
        .mask       (pick_mask_s),
        .cur        (task_id_q),
        .from_start (in_idle_s),
        .found      (pick_found_s),
        .pick       (pick_s)
    );

    // Next-state logic; every pulse/level output is decoded from the next state so it
    // lines up with the state register.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        task_id_d   = task_id_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        aborted_d   = 1'b0;
        acc_clear_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    mask_d = task_mask;
                    if (pick_found_s) begin
                        task_id_d = pick_s;
                        idx_d     = '0;
                        state_d   = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!hold) begin
                    if (idx_q == IDX_LAST) begin
                        if (ADD_LAT == 0) begin
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_W'(ADD_LAT - 1);
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_WRITE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_WRITE: begin
                if (pick_found_s) begin
                    task_id_d = pick_s;
                    idx_d     = '0;
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!in_idle_s && abort) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end

        if (state_d == ST_CLEAR) begin
            acc_clear_d[task_id_d] = 1'b1;
        end else begin
            acc_clear_d = '0;
        end
        res_valid_d = (state_d == ST_WRITE);
        res_task_d  = (state_d == ST_WRITE) ? task_id_d : '0;
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            task_id_q   <= TASK_W'(TASK_BIAS);
            idx_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            acc_clear_q <= '0;
            res_valid_q <= 1'b0;
            res_task_q  <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            task_id_q   <= task_id_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            acc_clear_q <= acc_clear_d;
            res_valid_q <= res_valid_d;
            res_task_q  <= res_task_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Accumulate enable must follow hold in the same cycle: the element is only
    // valid while the source is not holding.
    always_comb begin
        acc_en = '0;
        if ((state_q == ST_ISSUE) && !hold) begin
            acc_en[task_id_q] = 1'b1;
        end else begin
            acc_en = '0;
        end
    end

    assign busy      = busy_q;
    assign idx       = idx_q;
    assign task_id   = task_id_q;
    assign acc_clear = acc_clear_q;
    assign res_valid = res_valid_q;
    assign res_task  = res_task_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

`ifdef ADAPT_SCHED_PERF_EN
    logic [31:0] run_cycles_q, run_cycles_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating counters; they stop moving once busy drops.
    always_comb begin
        run_cycles_d   = run_cycles_q;
        stall_cycles_d = stall_cycles_q;
        if (start_acc_s) begin
            run_cycles_d   = 32'd0;
            stall_cycles_d = 32'd0;
        end else begin
            if (busy_q && (run_cycles_q != 32'hFFFF_FFFF)) begin
                run_cycles_d = run_cycles_q + 32'd1;
            end else begin
                run_cycles_d = run_cycles_q;
            end
            if ((state_q == ST_ISSUE) && hold && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles_q   <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            run_cycles_q   <= run_cycles_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign run_cycles   = run_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_adapter_bp_scheduler.sv
// Scoreboard bench for adapter_bp_scheduler: stimulus queues expected result/done/abort
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_adapter_bp_scheduler;

    localparam int SA_SIZE  = 576;
    localparam int N_TASKS  = 7;
    localparam int ADD_LAT  = 1;
    localparam int TASK_W   = 3;
    localparam int IDX_W    = 10;
    localparam int PER_TASK = SA_SIZE + ADD_LAT + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [N_TASKS-1:0] task_mask;
    logic               hold;
    logic               busy;
    logic [IDX_W-1:0]   idx;
    logic [TASK_W-1:0]  task_id;
    logic [N_TASKS-1:0] acc_clear;
    logic [N_TASKS-1:0] acc_en;
    logic               res_valid;
    logic [TASK_W-1:0]  res_task;
    logic               done;
    logic               aborted;
`ifdef ADAPT_SCHED_PERF_EN
    logic [31:0]        run_cycles;
    logic [31:0]        stall_cycles;
`endif

    adapter_bp_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .task_mask (task_mask),
        .hold      (hold),
        .busy      (busy),
        .idx       (idx),
        .task_id   (task_id),
        .acc_clear (acc_clear),
        .acc_en    (acc_en),
        .res_valid (res_valid),
        .res_task  (res_task),
        .done      (done),
        .aborted   (aborted)
`ifdef ADAPT_SCHED_PERF_EN
        ,
        .run_cycles   (run_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Event kinds: 0 = res_valid, 1 = done, 2 = aborted
    typedef struct {
        int kind;
        int tsk;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;   // after edge e (edges numbered from 0) this reads e+1
    int  en_cnt[N_TASKS];
    int  clr_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int tsk, input int c);
        ev_t e;
        e.kind = kind;
        e.tsk  = tsk;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input int tsk);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d task %0d at cycle %0d, none expected", kind, tsk, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_task", tsk, e.tsk);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            for (int k = 0; k < N_TASKS; k++) if (acc_en[k]) en_cnt[k]++;
            if (acc_clear != '0) clr_cnt++;
            check("exclusive_strobes",
                  32'(((|acc_clear) & (|acc_en)) | ((|acc_clear) & res_valid) | ((|acc_en) & res_valid)), 0);
            check("idx_in_range", 32'(idx <= IDX_W'(SA_SIZE - 1)), 1);
            if (res_valid) match_ev(0, int'(res_task));
            if (done)      match_ev(1, 0);
            if (aborted)   match_ev(2, 0);
        end
    end

    task automatic clear_counts();
        for (int k = 0; k < N_TASKS; k++) en_cnt[k] = 0;
        clr_cnt = 0;
    endtask

    // Queue the full run's events: task k is delayed by stall_len if k >= stall_task.
    task automatic plan_run(input logic [N_TASKS-1:0] m, input int t, input int stall_task, input int stall_len);
        int j;
        j = 0;
        for (int k = 0; k < N_TASKS; k++) begin
            if (m[k]) begin
                push(0, k, t + (j + 1) * PER_TASK + ((k >= stall_task) ? stall_len : 0));
                j++;
            end
        end
        push(1, 0, t + 1 + j * PER_TASK + stall_len);
    endtask

    task automatic launch(input logic [N_TASKS-1:0] m, input logic plan, output int t);
        @(negedge clk);
        t = cyc;
        if (plan) plan_run(m, t, N_TASKS, 0);
        start     = 1'b1;
        task_mask = m;
        @(negedge clk);
        start     = 1'b0;
        task_mask = '0;
    endtask

    task automatic wait_events(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check({name, "_events_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; task_mask = '0;
        clear_counts();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_idx", idx, 0);
        check("rst_task_id", task_id, 0);
        check("rst_acc_clear", acc_clear, 0);
        check("rst_acc_en", acc_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full run, all tasks: done at t+4054
        clear_counts();
        launch(7'h7F, 1'b1, t);
        #1 check("full_busy_after_start", busy, 1);
        wait_events("full", 5000);
        for (int k = 0; k < N_TASKS; k++) check("full_en_count", en_cnt[k], 576);
        check("full_clear_count", clr_cnt, 7);
        check("full_busy_after_done", busy, 0);

        // Sparse mask: tasks 0 and 2 only, done at t+1159
        clear_counts();
        launch(7'b0000101, 1'b1, t);
        wait_events("sparse", 2000);
        check("sparse_en0", en_cnt[0], 576);
        check("sparse_en1", en_cnt[1], 0);
        check("sparse_en2", en_cnt[2], 576);

        // Empty mask: done 1 cycle after start, no strobes
        clear_counts();
        launch(7'h00, 1'b1, t);
        wait_events("empty", 20);
        check("empty_clears", clr_cnt, 0);
        for (int k = 0; k < N_TASKS; k++) check("empty_en", en_cnt[k], 0);

        // Hold for 10 cycles at idx 100 of task 3: everything from task 3 on slips by 10
        clear_counts();
        @(negedge clk);
        t = cyc;
        plan_run(7'h7F, t, 3, 10);
        start = 1'b1; task_mask = 7'h7F;
        @(negedge clk);
        start = 1'b0; task_mask = '0;
        wait_cyc(t + 3 * PER_TASK + 2 + 100);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_idx", idx, 100);
            check("hold_task", task_id, 3);
            check("hold_acc_en", acc_en, 0);
            @(negedge clk);
        end
        hold = 1'b0;
        #1 check("hold_release_en", acc_en, 7'b0001000);
        wait_events("hold", 5000);
        for (int k = 0; k < N_TASKS; k++) check("hold_en_count", en_cnt[k], 576);
`ifdef ADAPT_SCHED_PERF_EN
        check("perf_run_cycles", run_cycles, 7 * PER_TASK + 10);
        check("perf_stall_cycles", stall_cycles, 10);
`endif

        // Abort during DRAIN of task 4
        clear_counts();
        launch(7'h7F, 1'b0, t);
        for (int k = 0; k < 4; k++) push(0, k, t + (k + 1) * PER_TASK);
        wait_cyc(t + 4 * PER_TASK + 578);
        check("drain_task", task_id, 4);
        check("drain_idx", idx, 575);
        check("drain_no_en", acc_en, 0);
        check("drain_busy", busy, 1);
        push(2, 0, cyc + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_res_valid", res_valid, 0);
        wait_events("abort", 100);
        check("abort_en4", en_cnt[4], 576);
        launch(7'h02, 1'b1, t);
        wait_events("after_abort", 1000);

        // Start while busy is ignored
        clear_counts();
        launch(7'h01, 1'b1, t);
        wait_cyc(t + 200);
        start = 1'b1; task_mask = 7'h7F;
        @(negedge clk);
        start = 1'b0; task_mask = '0;
        wait_events("start_busy", 1000);
        check("start_busy_en1", en_cnt[1], 0);
        check("start_busy_en0", en_cnt[0], 576);

        // start + abort together in IDLE is ignored
        clear_counts();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; task_mask = 7'h7F;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; task_mask = '0;
        #1 check("start_abort_busy", busy, 0);
        wait_events("start_abort", 20);
        check("start_abort_clears", clr_cnt, 0);

        // Async reset mid-run returns to reset values immediately
        launch(7'h7F, 1'b0, t);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_idx", idx, 0);
        check("midrst_acc_en", acc_en, 0);
        check("midrst_task", task_id, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_events("midrst", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
